// File: rtl/midi_parser_pkg.sv
// -----------------------------------------------------------------------------
// MIDI package: message types, the parsed message record and the per-type
// data-byte length used by the parser.
// No ports (package). Imported by midi_status_decode and midi_parser.
// -----------------------------------------------------------------------------
package MIDI;

    // Channel-voice message types, encoded as the status high nibble.
    typedef enum logic [3:0] {
        NOTE_OFF         = 4'h8,
        NOTE_ON          = 4'h9,
        POLY_PRESSURE    = 4'hA,
        CONTROL_CHANGE   = 4'hB,
        PROGRAM_CHANGE   = 4'hC,
        CHANNEL_PRESSURE = 4'hD,
        PITCH_BEND       = 4'hE
    } message_type_t;

    typedef struct packed {
        message_type_t message_type;
        logic [3:0]    channel;
        logic [6:0]    data_byte1;
        logic [6:0]    data_byte2;
    } message_t;

    localparam int DATA_LENGTH_ONE = 1;
    localparam int DATA_LENGTH_TWO = 2;

    // Number of data bytes that follow a channel status of the given type.
    function automatic int data_length(input logic [3:0] message_type);
        case (message_type)
            4'hC, 4'hD: data_length = DATA_LENGTH_ONE;
            default:    data_length = DATA_LENGTH_TWO;
        endcase
    endfunction

endpackage

// File: rtl/midi_parser_status_decode.sv
// -----------------------------------------------------------------------------
// midi_status_decode: purely combinational classification of one MIDI byte.
// Ports:
//   byte_data      in  8  received byte
//   is_status      out 1  bit 7 set
//   is_realtime    out 1  0xF8-0xFF
//   is_system      out 1  0xF0-0xF7 (system common / exclusive)
//   message_type   out 4  status high nibble
//   channel        out 4  status low nibble
//   needs_two_data out 1  message type carries two data bytes
// -----------------------------------------------------------------------------
module midi_status_decode
    import MIDI::*;
(
    input  logic [7:0] byte_data,
    output logic       is_status,
    output logic       is_realtime,
    output logic       is_system,
    output logic [3:0] message_type,
    output logic [3:0] channel,
    output logic       needs_two_data
);

    always_comb begin
        is_status      = byte_data[7];
        is_realtime    = (byte_data[7:3] == 5'b11111);
        is_system      = (byte_data[7:3] == 5'b11110);
        message_type   = byte_data[7:4];
        channel        = byte_data[3:0];
        needs_two_data = (data_length(byte_data[7:4]) == DATA_LENGTH_TWO);
    end

endmodule

// File: rtl/midi_parser.sv
// -----------------------------------------------------------------------------
// midi_parser: byte-stream MIDI channel-message parser with running status.
// Parameters:
//   CHANNEL  channel accepted when filtering is compiled in
// Ports:
//   clock_50_000_000 in  1  system clock (rising edge)
//   reset            in  1  synchronous, active-high reset
//   byte_data        in  8  received MIDI byte
//   byte_valid       in  1  byte_data strobe
//   message          out    last complete message (held between completions)
//   message_ready    out 1  one-cycle pulse, cycle after the final data byte
// Build option: define MIDI_CHANNEL_FILTER_EN to emit only messages on CHANNEL
// (other channels are still parsed so running status stays correct).
// -----------------------------------------------------------------------------
module midi_parser
    import MIDI::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clock_50_000_000,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output message_t   message,
    output logic       message_ready
);

    typedef enum logic [1:0] {
        WAIT_STATUS,
        WAIT_DATA1,
        WAIT_DATA2
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] run_type_reg, run_type_next;
    logic [3:0] run_channel_reg, run_channel_next;
    logic [6:0] data1_reg, data1_next;
    message_t   message_reg, message_next;
    logic       ready_reg, ready_next;

    logic       is_status, is_realtime, is_system, needs_two_data;
    logic [3:0] dec_type, dec_channel;
    logic       run_two_data;
    logic       channel_match;

    midi_status_decode u_decode (
        .byte_data      (byte_data),
        .is_status      (is_status),
        .is_realtime    (is_realtime),
        .is_system      (is_system),
        .message_type   (dec_type),
        .channel        (dec_channel),
        .needs_two_data (needs_two_data)
    );

    assign run_two_data = (data_length(run_type_reg) == DATA_LENGTH_TWO);

`ifdef MIDI_CHANNEL_FILTER_EN
    assign channel_match = (run_channel_reg == CHANNEL);
`else
    assign channel_match = 1'b1;
    logic unused_channel;
    assign unused_channel = ^CHANNEL;
`endif

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            state_reg       <= WAIT_STATUS;
            run_type_reg    <= 4'd0;
            run_channel_reg <= 4'd0;
            data1_reg       <= 7'd0;
            message_reg     <= '0;
            ready_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            run_type_reg    <= run_type_next;
            run_channel_reg <= run_channel_next;
            data1_reg       <= data1_next;
            message_reg     <= message_next;
            ready_reg       <= ready_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        run_type_next    = run_type_reg;
        run_channel_next = run_channel_reg;
        data1_next       = data1_reg;
        message_next     = message_reg;
        ready_next       = 1'b0;

        if (byte_valid) begin
            if (is_realtime) begin
                // Real-time bytes may interleave anywhere; they leave no trace.
            end else if (is_system) begin
                state_next       = WAIT_STATUS;
                run_type_next    = 4'd0;
                run_channel_next = 4'd0;
            end else if (is_status) begin
                // A new status abandons any partial message.
                state_next       = WAIT_DATA1;
                run_type_next    = dec_type;
                run_channel_next = dec_channel;
            end else begin
                case (state_reg)
                    WAIT_DATA1: begin
                        data1_next = byte_data[6:0];
                        if (run_two_data) begin
                            state_next = WAIT_DATA2;
                        end else if (channel_match) begin
                            message_next.message_type = message_type_t'(run_type_reg);
                            message_next.channel      = run_channel_reg;
                            message_next.data_byte1   = byte_data[6:0];
                            message_next.data_byte2   = 7'd0;
                            ready_next                = 1'b1;
                        end
                    end
                    WAIT_DATA2: begin
                        state_next = WAIT_DATA1;
                        if (channel_match) begin
                            // Note-on with zero velocity is a note-off.
                            if (run_type_reg == 4'h9 && byte_data[6:0] == 7'd0)
                                message_next.message_type = NOTE_OFF;
                            else
                                message_next.message_type = message_type_t'(run_type_reg);
                            message_next.channel    = run_channel_reg;
                            message_next.data_byte1 = data1_reg;
                            message_next.data_byte2 = byte_data[6:0];
                            ready_next              = 1'b1;
                        end
                    end
                    default: begin
                        // Data without a running status is discarded.
                    end
                endcase
            end
        end
    end

    assign message       = message_reg;
    assign message_ready = ready_reg;

endmodule

// File: tb/tb_midi_parser.sv
module tb_midi_parser;
    import MIDI::*;

    logic       clk;
    logic       reset;
    logic [7:0] byte_data;
    logic       byte_valid;
    message_t   message;
    logic       message_ready;

    int checks   = 0;
    int failures = 0;
    int pulse_count = 0;
    logic [21:0] pulse_msgs [$];

    midi_parser #(.CHANNEL(4'd2)) dut (
        .clock_50_000_000 (clk),
        .reset            (reset),
        .byte_data        (byte_data),
        .byte_valid       (byte_valid),
        .message          (message),
        .message_ready    (message_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every pulse and the message presented with it.
    always @(posedge clk) begin
        #1;
        if (message_ready) begin
            pulse_count++;
            pulse_msgs.push_back(message);
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s value=0x%0h", tag, observed);
        end
    endtask

    function automatic logic [21:0] mk(input logic [3:0] t, input logic [3:0] c,
                                       input logic [6:0] d1, input logic [6:0] d2);
        return {t, c, d1, d2};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_case();
        idle(2);
        pulse_count = 0;
        pulse_msgs.delete();
    endtask

    function automatic logic [31:0] msg_at(input int i);
        if (i < pulse_msgs.size()) return {10'd0, pulse_msgs[i]};
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        reset      = 1'b1;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        idle(3);
        check("reset_message", {10'd0, message}, 32'd0);
        check("reset_ready", {31'd0, message_ready}, 32'd0);
        reset = 1'b0;

`ifdef MIDI_CHANNEL_FILTER_EN
        start_case();
        send(8'h91); send(8'h3C); send(8'h64);
        idle(3);
        check("filter_other_ch_pulses", pulse_count, 0);
        check("filter_other_ch_msg", {10'd0, message}, 32'd0);
        start_case();
        send(8'h92); send(8'h3C); send(8'h64);
        idle(3);
        check("filter_own_ch_pulses", pulse_count, 1);
        check("filter_own_ch_msg", msg_at(0), {10'd0, mk(4'h9, 4'd2, 7'h3C, 7'h64)});
`else
        // Note-on, with pulse latency checked directly after the last strobe.
        start_case();
        send(8'h93); send(8'h3C);
        check("noteon_no_early_pulse", {31'd0, message_ready}, 32'd0);
        send(8'h64);
        check("noteon_pulse_latency", {31'd0, message_ready}, 32'd1);
        idle(3);
        check("noteon_pulses", pulse_count, 1);
        check("noteon_msg", msg_at(0), {10'd0, mk(4'h9, 4'd3, 7'h3C, 7'h64)});
        check("noteon_hold", {10'd0, message}, {10'd0, mk(4'h9, 4'd3, 7'h3C, 7'h64)});

        // Control change with running status and idle gaps between bytes.
        start_case();
        send(8'hB0); idle(2); send(8'h07); send(8'h7F); idle(4); send(8'h0A); send(8'h40);
        idle(3);
        check("cc_pulses", pulse_count, 2);
        check("cc_msg0", msg_at(0), {10'd0, mk(4'hB, 4'd0, 7'h07, 7'h7F)});
        check("cc_msg1", msg_at(1), {10'd0, mk(4'hB, 4'd0, 7'h0A, 7'h40)});

        // Zero-velocity note-on with an interleaved clock byte.
        start_case();
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h00);
        idle(3);
        check("vel0_pulses", pulse_count, 1);
        check("vel0_msg", msg_at(0), {10'd0, mk(4'h8, 4'd0, 7'h3C, 7'h00)});

        // One-byte program change with running status.
        start_case();
        send(8'hC5); send(8'h12); send(8'h13);
        idle(3);
        check("pc_pulses", pulse_count, 2);
        check("pc_msg0", msg_at(0), {10'd0, mk(4'hC, 4'd5, 7'h12, 7'h00)});
        check("pc_msg1", msg_at(1), {10'd0, mk(4'hC, 4'd5, 7'h13, 7'h00)});

        // Channel pressure and pitch bend.
        start_case();
        send(8'hD4); send(8'h55);
        send(8'hE1); send(8'h00); send(8'h40);
        idle(3);
        check("cp_pb_pulses", pulse_count, 2);
        check("cp_msg", msg_at(0), {10'd0, mk(4'hD, 4'd4, 7'h55, 7'h00)});
        check("pb_msg", msg_at(1), {10'd0, mk(4'hE, 4'd1, 7'h00, 7'h40)});

        // Reset mid-message discards the partial message.
        start_case();
        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h40);
        idle(3);
        check("midreset_pulses", pulse_count, 0);
        check("midreset_msg", {10'd0, message}, 32'd0);

        // Status byte mid-message abandons it; system byte kills running status.
        start_case();
        send(8'h90); send(8'h3C);
        send(8'hB1); send(8'h07); send(8'h7F);
        send(8'hF0); send(8'h3C); send(8'h40);
        idle(3);
        check("abandon_sys_pulses", pulse_count, 1);
        check("abandon_msg", msg_at(0), {10'd0, mk(4'hB, 4'd1, 7'h07, 7'h7F)});
        check("sys_hold_msg", {10'd0, message}, {10'd0, mk(4'hB, 4'd1, 7'h07, 7'h7F)});

        // Reset wins over a status byte strobed in the same cycle.
        start_case();
        @(negedge clk);
        reset      = 1'b1;
        byte_data  = 8'h93;
        byte_valid = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        byte_valid = 1'b0;
        send(8'h3C); send(8'h64);
        idle(3);
        check("reset_priority_pulses", pulse_count, 0);
        check("reset_priority_msg", {10'd0, message}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/midi_parser.md
MIDI_PARSER -- requirements
Module: MidiParser

Interface
REQ-001 SHALL have parameter CHANNEL, default 4'd0, the MIDI channel accepted when channel filtering is compiled in.
REQ-002 SHALL have port clock_50_000_000  input  1  system clock; the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port byte_data  input  8  received MIDI byte from the UART receiver.
REQ-005 SHALL have port byte_valid  input  1  one-cycle strobe; byte_data is valid this cycle.
REQ-006 SHALL have port message  output  MIDI::message_t  last complete message: message_type, channel, data_byte1, data_byte2.
REQ-007 SHALL have port message_ready  output  1  one-cycle pulse marking a new message.

Function
REQ-008 SHALL classify each byte: bit7=1 is a status byte, bit7=0 is a data byte.
REQ-009 SHALL implement FSM states WAIT_STATUS, WAIT_DATA1, WAIT_DATA2.
REQ-010 On channel status 0x80-0xEF: latch type (bits 7:4) and channel (bits 3:0) as running status; go to WAIT_DATA1.
REQ-011 Data length SHALL be 2 bytes for types 0x8, 0x9, 0xA, 0xB and 0xE, and 1 byte for types 0xC and 0xD.
REQ-012 In WAIT_DATA1, a data byte SHALL latch data_byte1. For 1-byte types, the message completes; otherwise go to WAIT_DATA2.
REQ-013 In WAIT_DATA2, a data byte SHALL latch data_byte2, complete the message, and return to WAIT_DATA1 (running status).
REQ-014 For 1-byte types, data_byte2 SHALL be 7'd0 and the FSM SHALL remain in WAIT_DATA1 after completion.
REQ-015 On completion, message SHALL update and message_ready SHALL pulse high for exactly one cycle, in the cycle after the final byte_valid.
REQ-016 message SHALL hold its value between completions.
REQ-017 Note-on (0x9) with data_byte2==0 SHALL be emitted as type NOTE_OFF with the same note and velocity 0.
REQ-018 Real-time bytes 0xF8-0xFF SHALL be ignored with no effect on FSM state, running status or partial data.
REQ-019 System common/exclusive bytes 0xF0-0xF7 SHALL clear running status and force WAIT_STATUS.
REQ-020 Data bytes in WAIT_STATUS SHALL be discarded.
REQ-021 A status byte arriving mid-message SHALL abandon the partial message (no pulse) and start the new one.
REQ-022 Cycles with byte_valid=0 SHALL leave all state unchanged; there is no timeout.

Reset
REQ-023 While reset=1 at a clock edge: FSM=WAIT_STATUS, running status cleared, message='0, message_ready=0.
REQ-024 Reset asserted mid-message SHALL discard the partial message; a following data byte is ignored until a new status byte arrives.
REQ-025 Reset SHALL take priority over a byte_valid in the same cycle.

Configuration
REQ-026 Macro MIDI_CHANNEL_FILTER_EN SHALL control channel filtering.
REQ-027 With MIDI_CHANNEL_FILTER_EN defined: messages whose channel != CHANNEL are parsed (running status tracked) but produce no message update and no pulse.
REQ-028 With MIDI_CHANNEL_FILTER_EN undefined: all channels are emitted and CHANNEL is unused.

Structure
REQ-029 The following SHALL live in package MIDI: message_t, the message_type enum (NOTE_OFF, NOTE_ON, POLY_PRESSURE, CONTROL_CHANGE, PROGRAM_CHANGE, CHANNEL_PRESSURE, PITCH_BEND), and the data-length constants.
REQ-030 The FSM state enum SHALL be local to the module.
REQ-031 Sub-module MidiStatusDecode SHALL be purely combinational: byte -> {is_status, is_realtime, is_system, type, channel, needs_two_data}.

Verification
REQ-032 Bytes 0x93,0x3C,0x64 -> one pulse; message = {NOTE_ON, ch3, 0x3C, 0x64}; pulse 1 cycle after the 0x64 strobe.
REQ-033 Bytes 0xB0,0x07,0x7F,0x0A,0x40 (running status) -> two pulses: {CC, ch0, 0x07, 0x7F} then {CC, ch0, 0x0A, 0x40}.
REQ-034 Bytes 0x90,0x3C,0xF8,0x00 -> one pulse: {NOTE_OFF, ch0, 0x3C, 0x00}.
REQ-035 Bytes 0xC5,0x12,0x13 -> two pulses: {PROGRAM_CHANGE, ch5, 0x12, 0x00} then {PROGRAM_CHANGE, ch5, 0x13, 0x00}.
REQ-036 Bytes 0x90,0x3C then reset then 0x40 -> no pulse; message == '0.
REQ-037 With MIDI_CHANNEL_FILTER_EN and CHANNEL=2: bytes 0x91,0x3C,0x64 -> no pulse; then 0x92,0x3C,0x64 -> one pulse.
